// File: rtl/ci_pkg.sv
`default_nettype none
// ============================================================================
// ci_pkg : shared types and constants for the custom-instruction initiator
// Rev 1.0
// ============================================================================
package ci_pkg;

    localparam int         CI_ADDR_WIDTH  = 9;
    localparam int         CI_WRITE_BIT   = 9;
    localparam logic [7:0] CI_DEFAULT_ID  = 8'd14;
    localparam int         CI_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        CI_IDLE  = 2'd0,
        CI_ISSUE = 2'd1,
        CI_WAIT  = 2'd2,
        CI_RESP  = 2'd3
    } ci_state_t;

    // Operand A carries the direction flag just above the word address.
    function automatic logic [31:0] ci_pack_a(input logic                     write,
                                              input logic [CI_ADDR_WIDTH-1:0] addr);
        logic [31:0] a;
        a                    = '0;
        a[CI_ADDR_WIDTH-1:0] = addr;
        a[CI_WRITE_BIT]      = write;
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ci_timeout_counter.sv
`default_nettype none
// ============================================================================
// ci_timeout_counter : WAIT-cycle counter with clear, enable and terminal count
// Rev 1.0
// ============================================================================
module ci_timeout_counter
    import ci_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    typedef logic [CI_COUNT_WIDTH-1:0] count_t;

    // terminal marks the LIMIT-th waiting cycle, so the count never exceeds LIMIT-1.
    localparam count_t LAST = count_t'(LIMIT - 1);

    count_t count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + count_t'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/ci_initiator.sv
`default_nettype none
// ============================================================================
// ci_initiator : turns read/write commands into custom-instruction transactions
// Rev 1.0
// ============================================================================
module ci_initiator
    import ci_pkg::*;
#(
    parameter logic [7:0] customId      = CI_DEFAULT_ID,
    parameter int         timeoutCycles = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic                     cmdWrite,
    input  logic [CI_ADDR_WIDTH-1:0] cmdAddr,
    input  logic [31:0]              cmdData,
    output logic                     ciStart,
    output logic [7:0]               ciN,
    output logic [31:0]              ciValueA,
    output logic [31:0]              ciValueB,
    input  logic                     ciDone,
    input  logic [31:0]              ciResult,
    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [31:0]              rspData,
    output logic                     rspTimeout
);

    ci_state_t state;
    ci_state_t state_next;

    logic                     held_write;
    logic [CI_ADDR_WIDTH-1:0] held_addr;
    logic [31:0]              held_data;
    logic [31:0]              rsp_data_q;
    logic                     rsp_timeout_q;

    logic take_cmd;
    logic take_result;
    logic take_timeout;
    logic count_clear;
    logic count_enable;
    logic count_terminal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= CI_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        take_cmd     = 1'b0;
        take_result  = 1'b0;
        take_timeout = 1'b0;
        count_clear  = 1'b0;
        count_enable = 1'b0;
        case (state)
            CI_IDLE: begin
                if (cmdValid) begin
                    take_cmd   = 1'b1;
                    state_next = CI_ISSUE;
                end
            end
            CI_ISSUE: begin
                if (ciDone) begin
                    take_result = 1'b1;
                    state_next  = CI_RESP;
                end else begin
                    count_clear = 1'b1;
                    state_next  = CI_WAIT;
                end
            end
            CI_WAIT: begin
                // A completion arriving on the last allowed cycle beats the timeout.
                if (ciDone) begin
                    take_result = 1'b1;
                    state_next  = CI_RESP;
                end else if (count_terminal) begin
                    take_timeout = 1'b1;
                    state_next   = CI_RESP;
                end else begin
                    count_enable = 1'b1;
                end
            end
            CI_RESP: begin
                if (rspReady) begin
                    state_next = CI_IDLE;
                end
            end
            default: begin
                state_next = CI_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held_write <= 1'b0;
            held_addr  <= '0;
            held_data  <= '0;
        end else if (take_cmd) begin
            held_write <= cmdWrite;
            held_addr  <= cmdAddr;
            held_data  <= cmdData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else if (take_result) begin
            rsp_data_q    <= ciResult;
            rsp_timeout_q <= 1'b0;
        end else if (take_timeout) begin
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
        end
    end

    ci_timeout_counter #(
        .LIMIT (timeoutCycles)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (count_clear),
        .enable   (count_enable),
        .terminal (count_terminal)
    );

    // Instruction bus is only non-zero during the single ISSUE cycle.
    assign cmdReady   = (state == CI_IDLE);
    assign ciStart    = (state == CI_ISSUE);
    assign ciN        = (state == CI_ISSUE) ? customId : 8'd0;
    assign ciValueA   = (state == CI_ISSUE) ? ci_pack_a(held_write, held_addr) : 32'd0;
    assign ciValueB   = (state == CI_ISSUE && held_write) ? held_data : 32'd0;
    assign rspValid   = (state == CI_RESP);
    assign rspData    = rsp_data_q;
    assign rspTimeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ci_initiator.sv
`default_nettype none
// ============================================================================
// tb_ci_initiator : randomized transaction bench with a transaction-level model
// Rev 1.0
// ============================================================================
module tb_ci_initiator;

    localparam logic [7:0] ID = 8'd14;
    localparam int         TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic        cmdWrite = 1'b0;
    logic [8:0]  cmdAddr = '0;
    logic [31:0] cmdData = '0;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone = 1'b0;
    logic [31:0] ciResult = '0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [31:0] rspData;
    logic        rspTimeout;

    int num_checks = 0;
    int num_errors = 0;

    ci_initiator #(
        .customId      (ID),
        .timeoutCycles (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdWrite   (cmdWrite),
        .cmdAddr    (cmdAddr),
        .cmdData    (cmdData),
        .ciStart    (ciStart),
        .ciN        (ciN),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciDone     (ciDone),
        .ciResult   (ciResult),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspData    (rspData),
        .rspTimeout (rspTimeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Random command traffic that must be ignored while busy.
    task automatic junk_cmd();
        cmdValid = 1'($urandom_range(0, 1));
        cmdWrite = 1'($urandom_range(0, 1));
        cmdAddr  = 9'($urandom());
        cmdData  = $urandom();
    endtask

    task automatic check_bus_quiet(input string tag);
        check({tag, "_ciStart"}, {31'd0, ciStart}, 32'd0);
        check({tag, "_ciN"}, {24'd0, ciN}, 32'd0);
        check({tag, "_ciValueA"}, ciValueA, 32'd0);
        check({tag, "_ciValueB"}, ciValueB, 32'd0);
    endtask

    // done_delay: 0 = done during ISSUE, k = done on k-th WAIT cycle, >TO = never.
    task automatic run_txn(input logic wr, input logic [8:0] addr, input logic [31:0] data,
                           input int done_delay, input logic [31:0] result, input int ready_delay);
        int          waits;
        logic        exp_to;
        logic [31:0] exp_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;

        if (done_delay == 0) begin
            waits = 0;  exp_to = 1'b0; exp_data = result;
        end else if (done_delay <= TO) begin
            waits = done_delay; exp_to = 1'b0; exp_data = result;
        end else begin
            waits = TO; exp_to = 1'b1; exp_data = 32'd0;
        end
        exp_a = (wr ? 32'd512 : 32'd0) + 32'(addr);
        exp_b = wr ? data : 32'd0;

        check("accept_cmdReady", {31'd0, cmdReady}, 32'd1);
        cmdValid = 1'b1;
        cmdWrite = wr;
        cmdAddr  = addr;
        cmdData  = data;
        ciDone   = 1'b0;
        rspReady = 1'($urandom_range(0, 1));
        step();

        junk_cmd();
        check("issue_ciStart", {31'd0, ciStart}, 32'd1);
        check("issue_ciN", {24'd0, ciN}, {24'd0, ID});
        check("issue_ciValueA", ciValueA, exp_a);
        check("issue_ciValueB", ciValueB, exp_b);
        check("issue_cmdReady", {31'd0, cmdReady}, 32'd0);
        check("issue_rspValid", {31'd0, rspValid}, 32'd0);
        ciDone   = (done_delay == 0);
        ciResult = (done_delay == 0) ? result : $urandom();
        step();

        for (int k = 1; k <= waits; k++) begin
            junk_cmd();
            check("wait_rspValid", {31'd0, rspValid}, 32'd0);
            check("wait_cmdReady", {31'd0, cmdReady}, 32'd0);
            check_bus_quiet("wait");
            ciDone   = (k == done_delay);
            ciResult = (k == done_delay) ? result : $urandom();
            step();
        end

        ciDone = 1'b0;
        for (int r = 0; r <= ready_delay; r++) begin
            check("resp_rspValid", {31'd0, rspValid}, 32'd1);
            check("resp_rspData", rspData, exp_data);
            check("resp_rspTimeout", {31'd0, rspTimeout}, {31'd0, exp_to});
            check("resp_cmdReady", {31'd0, cmdReady}, 32'd0);
            check("resp_ciStart", {31'd0, ciStart}, 32'd0);
            if (r < ready_delay) begin
                rspReady = 1'b0;
                junk_cmd();
                ciDone   = 1'($urandom_range(0, 1));
                ciResult = $urandom();
                step();
            end
        end
        rspReady = 1'b1;
        cmdValid = 1'b0;
        ciDone   = 1'b0;
        step();
        check("after_rspValid", {31'd0, rspValid}, 32'd0);
        check("after_cmdReady", {31'd0, cmdReady}, 32'd1);
        rspReady = 1'b0;
    endtask

    initial begin
        // Reset held across a few edges, released away from the clock edge.
        step();
        step();
        check("rst_cmdReady", {31'd0, cmdReady}, 32'd1);
        check("rst_rspValid", {31'd0, rspValid}, 32'd0);
        check("rst_rspData", rspData, 32'd0);
        check("rst_rspTimeout", {31'd0, rspTimeout}, 32'd0);
        check_bus_quiet("rst");
        @(negedge clock);
        reset = 1'b1;
        step();
        check("post_rst_cmdReady", {31'd0, cmdReady}, 32'd1);

        // Spurious completion while idle.
        ciDone   = 1'b1;
        ciResult = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spur_rspValid", {31'd0, rspValid}, 32'd0);
            check("spur_rspData", rspData, 32'd0);
            check("spur_cmdReady", {31'd0, cmdReady}, 32'd1);
        end
        ciDone = 1'b0;

        run_txn(1'b1, 9'h000, 32'h42, 0, 32'h1234_5678, 0);
        run_txn(1'b0, 9'h037, 32'hFFFF_FFFF, 1, 32'h57, 0);
        run_txn(1'b0, 9'h1A5, 32'h0, TO + 5, 32'hBAD0_BAD0, 0);
        run_txn(1'b1, 9'h0F0, 32'hCAFE_F00D, 2, 32'h0BAD_BEEF, 0);
        run_txn(1'b1, 9'h155, 32'h8000_0001, 0, 32'h7777_0000, 5);
        run_txn(1'b0, 9'h1FF, 32'h0, TO, 32'hA5A5_5A5A, 1);
        run_txn(1'b0, 9'h001, 32'h0, TO + 1, 32'h1111_1111, 2);

        // Reset in the middle of WAIT abandons the transaction.
        cmdValid = 1'b1;
        cmdWrite = 1'b0;
        cmdAddr  = 9'h0AA;
        step();
        cmdValid = 1'b0;
        ciDone   = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_rspValid", {31'd0, rspValid}, 32'd0);
        check("midrst_rspTimeout", {31'd0, rspTimeout}, 32'd0);
        check("midrst_rspData", rspData, 32'd0);
        check_bus_quiet("midrst");
        step();
        @(negedge clock);
        reset    = 1'b1;
        rspReady = 1'b1;
        for (int i = 0; i < TO + 4; i++) begin
            step();
            check("postrst_rspValid", {31'd0, rspValid}, 32'd0);
            check("postrst_cmdReady", {31'd0, cmdReady}, 32'd1);
        end
        rspReady = 1'b0;

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), 9'($urandom()), $urandom(),
                    int'($urandom_range(0, TO + 3)), $urandom(),
                    int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ci_initiator.md
CI_INITIATOR -- requirements
Module: ci_initiator

Interface
REQ-001 Parameter customId, default 8'd14, custom-instruction number driven on ciN during issue.
REQ-002 Parameter timeoutCycles, default 16, maximum WAIT cycles before abort; range 1..255.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-005 cmdValid  in  1  command present.
REQ-006 cmdReady  out  1  initiator accepts command this cycle.
REQ-007 cmdWrite  in  1  1 = write, 0 = read.
REQ-008 cmdAddr  in  9  target word address.
REQ-009 cmdData  in  32  write data; ignored on read.
REQ-010 ciStart  out  1  custom-instruction start strobe.
REQ-011 ciN  out  8  custom-instruction number.
REQ-012 ciValueA  out  32  operand A.
REQ-013 ciValueB  out  32  operand B.
REQ-014 ciDone  in  1  responder completion, may be combinational from ciStart.
REQ-015 ciResult  in  32  responder result, valid only with ciDone.
REQ-016 rspValid  out  1  response available.
REQ-017 rspReady  in  1  consumer takes response.
REQ-018 rspData  out  32  captured ciResult, or 0 on timeout.
REQ-019 rspTimeout  out  1  response ended by timeout.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered or decoded from state and held registers only.
REQ-021 IDLE: cmdReady=1; on cmdValid, latch cmdWrite/cmdAddr/cmdData and go to ISSUE.
REQ-022 ISSUE lasts exactly one cycle: ciStart=1, ciN=customId, ciValueA={22'b0, write, addr[8:0]}, ciValueB=data on write, 0 on read.
REQ-023 Outside ISSUE: ciStart=0, ciN=0, ciValueA=0, ciValueB=0.
REQ-024 ISSUE with ciDone=1: capture ciResult into rspData, rspTimeout=0, go to RESP.
REQ-025 ISSUE with ciDone=0: clear timeout counter, go to WAIT.
REQ-026 WAIT: ciDone=1 captures ciResult and goes to RESP; otherwise counter increments.
REQ-027 WAIT: counter reaching timeoutCycles with ciDone=0 sets rspData=0, rspTimeout=1, goes to RESP.
REQ-028 ciDone and timeout in the same cycle: ciDone wins, rspTimeout=0.
REQ-029 RESP: rspValid=1, rspData/rspTimeout stable until rspReady=1; then IDLE.
REQ-030 cmdReady=0 in ISSUE, WAIT, RESP; no command queuing.
REQ-031 ciDone in IDLE or RESP is ignored; no state or output change.
REQ-032 Latency, ciDone in ISSUE, rspReady held high: accept cycle N, ciStart N+1, rspValid N+2, next cmdReady N+3.
REQ-033 Latency, ciDone one cycle after ciStart: rspValid N+3.
REQ-034 Counter width 8 bits; no wrap-around before timeout.

Reset
REQ-035 reset=0 forces state IDLE immediately, asynchronously.
REQ-036 Reset values: cmdReady=1 after release; ciStart=0, ciN=0, ciValueA=0, ciValueB=0, rspValid=0, rspData=0, rspTimeout=0, counter=0.
REQ-037 Reset in ISSUE/WAIT/RESP abandons the transaction; no response emitted after release.

Structure
REQ-038 Package ci_pkg holds the state enum, CI_ADDR_WIDTH=9, CI_WRITE_BIT=9 and CI_DEFAULT_ID=8'd14.
REQ-039 One sub-module, ci_timeout_counter (clear, enable, terminal-count output), holds the WAIT counter.

Verification
REQ-040 Write, combinational done: cmdWrite=1, addr=0x000, data=0x42, ciDone=1 in ISSUE -> ciValueA=0x200, ciValueB=0x42, ciN=14 for one cycle; rspValid two cycles after accept, rspTimeout=0.
REQ-041 Read, done one cycle later: addr=0x037, ciResult=0x57 with ciDone in WAIT -> ciValueA=0x037, ciValueB=0, rspData=0x57, rspValid three cycles after accept.
REQ-042 Timeout: read, ciDone never asserted, timeoutCycles=16 -> rspTimeout=1, rspData=0 after 16 WAIT cycles; next command accepted normally.
REQ-043 Backpressure: rspReady low 5 cycles -> rspValid, rspData held, cmdReady=0; new cmdValid ignored until handshake.
REQ-044 Reset mid-WAIT: reset=0 asynchronously -> all outputs at reset values same cycle; no rspValid after release.
REQ-045 Spurious ciDone in IDLE with ciResult=0xDEAD -> rspValid stays 0, rspData stays 0.
